// File: rtl/dest_reg_pipe.sv
// dest_reg_pipe: destination-register tracking and RAW interlock across EX/MEM/WB
module dest_reg_pipe #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       id_wr_reg,
    input  logic             id_wr_en,
    input  logic [2:0]       id_rs,
    input  logic [2:0]       id_rt,
    input  logic             id_rs_vld,
    input  logic             id_rt_vld,
    input  logic             flush,
    input  logic             mem_busy,
    output logic             hazard,
    output logic [2:0]       ex_wr_reg,
    output logic [2:0]       mem_wr_reg,
    output logic [2:0]       wb_wr_reg,
    output logic             ex_wr_en,
    output logic             mem_wr_en,
    output logic             wb_wr_en,
    output logic [CNT_W-1:0] bubble_cnt
);
    logic [2:0]       ex_wr_reg_q, mem_wr_reg_q, wb_wr_reg_q;
    logic             ex_wr_en_q, mem_wr_en_q, wb_wr_en_q;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             flush_pend_q;
    logic             flush_eff, rs_hit, rt_hit;

    // RAW match against EX/MEM only; WB is covered by the register-file bypass
    always_comb begin
        rs_hit       = id_rs_vld & ((ex_wr_en_q & (id_rs == ex_wr_reg_q)) | (mem_wr_en_q & (id_rs == mem_wr_reg_q)));
        rt_hit       = id_rt_vld & ((ex_wr_en_q & (id_rt == ex_wr_reg_q)) | (mem_wr_en_q & (id_rt == mem_wr_reg_q)));
        flush_eff    = flush | flush_pend_q;
        hazard       = (rs_hit | rt_hit) & ~flush_eff & ~rst;
        bubble_cnt_d = &bubble_cnt_q ? bubble_cnt_q : bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Stage advance with freeze, flush and bubble insertion; a killed EX slot is all zeros
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_wr_reg_q  <= 3'b000;
            mem_wr_reg_q <= 3'b000;
            wb_wr_reg_q  <= 3'b000;
            ex_wr_en_q   <= 1'b0;
            mem_wr_en_q  <= 1'b0;
            wb_wr_en_q   <= 1'b0;
            bubble_cnt_q <= '0;
            flush_pend_q <= 1'b0;
        end else if (mem_busy) begin
            flush_pend_q <= flush_pend_q | flush;
        end else begin
            mem_wr_reg_q <= ex_wr_reg_q;
            mem_wr_en_q  <= ex_wr_en_q;
            wb_wr_reg_q  <= mem_wr_reg_q;
            wb_wr_en_q   <= mem_wr_en_q;
            ex_wr_reg_q  <= (flush_eff | hazard) ? 3'b000 : id_wr_reg;
            ex_wr_en_q   <= (flush_eff | hazard) ? 1'b0 : id_wr_en;
            bubble_cnt_q <= hazard ? bubble_cnt_d : bubble_cnt_q;
            flush_pend_q <= 1'b0;
        end
    end

    assign ex_wr_reg  = ex_wr_reg_q;
    assign mem_wr_reg = mem_wr_reg_q;
    assign wb_wr_reg  = wb_wr_reg_q;
    assign ex_wr_en   = ex_wr_en_q;
    assign mem_wr_en  = mem_wr_en_q;
    assign wb_wr_en   = wb_wr_en_q;
    assign bubble_cnt = bubble_cnt_q;
endmodule

// File: tb/tb_dest_reg_pipe.sv
// tb_dest_reg_pipe: scenario bench for the destination-register pipe and RAW interlock
module tb_dest_reg_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] id_wr_reg, id_rs, id_rt;
    logic       id_wr_en, id_rs_vld, id_rt_vld, flush, mem_busy;
    logic       hazard;
    logic [2:0] ex_wr_reg, mem_wr_reg, wb_wr_reg;
    logic       ex_wr_en, mem_wr_en, wb_wr_en;
    logic [1:0] bubble_cnt;

    int vec = 0;
    int err = 0;
    logic [3:0] sb[$];
    logic [3:0] exp;

    dest_reg_pipe #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst),
        .id_wr_reg(id_wr_reg), .id_wr_en(id_wr_en),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_vld(id_rs_vld), .id_rt_vld(id_rt_vld),
        .flush(flush), .mem_busy(mem_busy), .hazard(hazard),
        .ex_wr_reg(ex_wr_reg), .mem_wr_reg(mem_wr_reg), .wb_wr_reg(wb_wr_reg),
        .ex_wr_en(ex_wr_en), .mem_wr_en(mem_wr_en), .wb_wr_en(wb_wr_en),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_wr_reg = 3'd0; id_wr_en = 1'b0;
        id_rs = 3'd0; id_rt = 3'd0; id_rs_vld = 1'b0; id_rt_vld = 1'b0;
        flush = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        step();
        step();
        #1;
        vec++; if ({ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en} !== 12'h000) begin err++; $display("FAIL reset_stages got=%h exp=000", {ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en}); end
        vec++; if (bubble_cnt !== 2'd0) begin err++; $display("FAIL reset_cnt got=%0d exp=0", bubble_cnt); end
        vec++; if (hazard !== 1'b0) begin err++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
        rst = 1'b0;
        sb.delete();
        id_wr_reg = 3'd5; id_wr_en = 1'b1;
        sb.push_back({3'd5, 1'b1});
        step();
        idle();
        vec++; if ({ex_wr_reg, ex_wr_en} !== 4'b1011) begin err++; $display("FAIL issue_ex got=%h exp=b", {ex_wr_reg, ex_wr_en}); end
        step();
        vec++; if ({mem_wr_reg, mem_wr_en, wb_wr_en} !== 5'b10110) begin err++; $display("FAIL issue_mem got=%b exp=10110", {mem_wr_reg, mem_wr_en, wb_wr_en}); end
        step();
        exp = sb.pop_front();
        vec++; if ({wb_wr_reg, wb_wr_en} !== exp) begin err++; $display("FAIL issue_wb got=%h exp=%h", {wb_wr_reg, wb_wr_en}, exp); end
    endtask

    task automatic test_ex_raw();
        do_reset();
        id_wr_reg = 3'd3; id_wr_en = 1'b1;
        sb.push_back({3'd3, 1'b1});
        step();
        id_wr_reg = 3'd1; id_wr_en = 1'b1; id_rs = 3'd3; id_rs_vld = 1'b0;
        #1;
        vec++; if (hazard !== 1'b0) begin err++; $display("FAIL ex_raw_novld got=%b exp=0", hazard); end
        id_rs_vld = 1'b1;
        #1;
        vec++; if (hazard !== 1'b1) begin err++; $display("FAIL ex_raw_hz0 got=%b exp=1", hazard); end
        step();
        vec++; if ({ex_wr_reg, ex_wr_en, bubble_cnt, hazard} !== 7'b0000011) begin err++; $display("FAIL ex_raw_b1 got=%b exp=0000011", {ex_wr_reg, ex_wr_en, bubble_cnt, hazard}); end
        step();
        vec++; if ({ex_wr_reg, ex_wr_en, bubble_cnt, hazard} !== 7'b0000100) begin err++; $display("FAIL ex_raw_b2 got=%b exp=0000100", {ex_wr_reg, ex_wr_en, bubble_cnt, hazard}); end
        exp = sb.pop_front();
        vec++; if ({wb_wr_reg, wb_wr_en} !== exp) begin err++; $display("FAIL ex_raw_prod_wb got=%h exp=%h", {wb_wr_reg, wb_wr_en}, exp); end
        sb.push_back({3'd1, 1'b1});
        step();
        idle();
        vec++; if ({ex_wr_reg, ex_wr_en, bubble_cnt} !== 6'b001110) begin err++; $display("FAIL ex_raw_cons_ex got=%b exp=001110", {ex_wr_reg, ex_wr_en, bubble_cnt}); end
        step();
        step();
        exp = sb.pop_front();
        vec++; if ({wb_wr_reg, wb_wr_en} !== exp) begin err++; $display("FAIL ex_raw_cons_wb got=%h exp=%h", {wb_wr_reg, wb_wr_en}, exp); end
    endtask

    task automatic test_mem_raw();
        do_reset();
        id_wr_reg = 3'd6; id_wr_en = 1'b1;
        sb.push_back({3'd6, 1'b1});
        step();
        id_wr_reg = 3'd2;
        sb.push_back({3'd2, 1'b1});
        step();
        id_wr_reg = 3'd4; id_rt = 3'd6; id_rt_vld = 1'b1;
        #1;
        vec++; if (hazard !== 1'b1) begin err++; $display("FAIL mem_raw_hz got=%b exp=1", hazard); end
        step();
        vec++; if ({ex_wr_reg, ex_wr_en, bubble_cnt, hazard} !== 7'b0000010) begin err++; $display("FAIL mem_raw_bubble got=%b exp=0000010", {ex_wr_reg, ex_wr_en, bubble_cnt, hazard}); end
        exp = sb.pop_front();
        vec++; if ({wb_wr_reg, wb_wr_en} !== exp) begin err++; $display("FAIL mem_raw_wb_only got=%h exp=%h", {wb_wr_reg, wb_wr_en}, exp); end
        step();
        idle();
        vec++; if ({ex_wr_reg, ex_wr_en, bubble_cnt} !== 6'b100101) begin err++; $display("FAIL mem_raw_cons_ex got=%b exp=100101", {ex_wr_reg, ex_wr_en, bubble_cnt}); end
    endtask

    task automatic test_flush();
        do_reset();
        id_wr_reg = 3'd3; id_wr_en = 1'b1;
        step();
        id_wr_reg = 3'd1; id_rs = 3'd3; id_rs_vld = 1'b1;
        #1;
        vec++; if (hazard !== 1'b1) begin err++; $display("FAIL flush_pre_hz got=%b exp=1", hazard); end
        flush = 1'b1;
        #1;
        vec++; if (hazard !== 1'b0) begin err++; $display("FAIL flush_hz got=%b exp=0", hazard); end
        step();
        idle();
        vec++; if ({ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, bubble_cnt} !== 10'b0000011100) begin err++; $display("FAIL flush_ex got=%b exp=0000011100", {ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, bubble_cnt}); end
    endtask

    task automatic test_freeze_flush();
        do_reset();
        id_wr_en = 1'b1;
        id_wr_reg = 3'd1; sb.push_back({3'd1, 1'b1}); step();
        id_wr_reg = 3'd2; sb.push_back({3'd2, 1'b1}); step();
        id_wr_reg = 3'd4; sb.push_back({3'd4, 1'b1}); step();
        exp = sb.pop_front();
        vec++; if ({wb_wr_reg, wb_wr_en} !== exp) begin err++; $display("FAIL frz_pre_wb got=%h exp=%h", {wb_wr_reg, wb_wr_en}, exp); end
        id_wr_reg = 3'd5; id_rs = 3'd4; id_rs_vld = 1'b1; mem_busy = 1'b1;
        step();
        vec++; if ({ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en, hazard} !== 13'b1001010100111) begin err++; $display("FAIL frz_hold1 got=%b exp=1001010100111", {ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en, hazard}); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        vec++; if (hazard !== 1'b0) begin err++; $display("FAIL frz_pend_hz got=%b exp=0", hazard); end
        step();
        vec++; if ({ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en, bubble_cnt} !== 14'b10010101001100) begin err++; $display("FAIL frz_hold3 got=%b exp=10010101001100", {ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en, bubble_cnt}); end
        mem_busy = 1'b0; id_rs_vld = 1'b0;
        step();
        exp = sb.pop_front();
        vec++; if ({ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, bubble_cnt} !== 10'b0000100100) begin err++; $display("FAIL frz_release got=%b exp=0000100100", {ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, bubble_cnt}); end
        vec++; if ({wb_wr_reg, wb_wr_en} !== exp) begin err++; $display("FAIL frz_release_wb got=%h exp=%h", {wb_wr_reg, wb_wr_en}, exp); end
        step();
        idle();
        vec++; if ({ex_wr_reg, ex_wr_en} !== 4'b1011) begin err++; $display("FAIL frz_next_ex got=%h exp=b", {ex_wr_reg, ex_wr_en}); end
    endtask

    task automatic test_saturation();
        do_reset();
        id_wr_reg = 3'd7; id_wr_en = 1'b1; id_rs = 3'd7; id_rs_vld = 1'b1;
        for (int i = 0; i < 5; i++) step();
        vec++; if (bubble_cnt !== 2'd3) begin err++; $display("FAIL sat_three got=%0d exp=3", bubble_cnt); end
        for (int i = 0; i < 3; i++) step();
        vec++; if (bubble_cnt !== 2'd3) begin err++; $display("FAIL sat_hold got=%0d exp=3", bubble_cnt); end
        vec++; if ({mem_wr_reg, mem_wr_en} !== 4'hf) begin err++; $display("FAIL sat_mem_valid got=%h exp=f", {mem_wr_reg, mem_wr_en}); end
        mem_busy = 1'b1; flush = 1'b1;
        step();
        rst = 1'b1;
        step();
        vec++; if ({ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en, bubble_cnt} !== 14'd0) begin err++; $display("FAIL midrst_clear got=%b exp=0", {ex_wr_reg, ex_wr_en, mem_wr_reg, mem_wr_en, wb_wr_reg, wb_wr_en, bubble_cnt}); end
        rst = 1'b0;
        idle();
        id_wr_reg = 3'd2; id_wr_en = 1'b1;
        step();
        idle();
        vec++; if ({ex_wr_reg, ex_wr_en} !== 4'b0101) begin err++; $display("FAIL midrst_pend_cleared got=%h exp=5", {ex_wr_reg, ex_wr_en}); end
    endtask

    initial begin
        test_reset();
        test_ex_raw();
        test_mem_raw();
        test_flush();
        test_freeze_flush();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
